// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - RV32I opcodes, funct3 codes, FSM/ALU enums and immediate decoders
package riscv_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4;
    localparam logic [2:0] F3_SR   = 3'd5;
    localparam logic [2:0] F3_OR   = 3'd6;
    localparam logic [2:0] F3_AND  = 3'd7;

    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_BLT  = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6;
    localparam logic [2:0] F3_BGEU = 3'd7;

    localparam logic [2:0] F3_B    = 3'd0;
    localparam logic [2:0] F3_H    = 3'd1;
    localparam logic [2:0] F3_W    = 3'd2;
    localparam logic [2:0] F3_BU   = 3'd4;
    localparam logic [2:0] F3_HU   = 3'd5;

    typedef enum logic {
        ST_EXEC,
        ST_LOAD_WB
    } state_t;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_t;

    function automatic logic [31:0] imm_i(input logic [11:0] f);
        return {{20{f[11]}}, f};
    endfunction

    function automatic logic [31:0] imm_s(input logic [6:0] hi, input logic [4:0] lo);
        return {{20{hi[6]}}, hi, lo};
    endfunction

    function automatic logic [31:0] imm_b(input logic [6:0] hi, input logic [4:0] lo);
        return {{19{hi[6]}}, hi[6], lo[0], hi[5:0], lo[4:1], 1'b0};
    endfunction

    function automatic logic [31:0] imm_u(input logic [19:0] f);
        return {f, 12'b0};
    endfunction

    function automatic logic [31:0] imm_j(input logic [19:0] f);
        return {{11{f[19]}}, f[19], f[7:0], f[8], f[18:9], 1'b0};
    endfunction

endpackage

// File: rtl/riscv_alu.sv
// rtl/riscv_alu.sv - combinational RV32I ALU with branch compare flags
module riscv_alu
    import riscv_pkg::*;
(
    input  alu_op_t     op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        eq,
    output logic        lt,
    output logic        ltu
);

    assign eq  = (a == b);
    assign lt  = ($signed(a) < $signed(b));
    assign ltu = (a < b);

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_SLL:  result = a << b[4:0];
            ALU_SLT:  result = {31'b0, lt};
            ALU_SLTU: result = {31'b0, ltu};
            ALU_XOR:  result = a ^ b;
            ALU_SRL:  result = a >> b[4:0];
            ALU_SRA:  result = $unsigned($signed(a) >>> b[4:0]);
            ALU_OR:   result = a | b;
            ALU_AND:  result = a & b;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/riscv_cpu.sv
// rtl/riscv_cpu.sv - multi-cycle RV32I core: 1-cycle execute, 2-cycle loads
module riscv_cpu
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        resetn,
    output logic [31:0] inst_addr,
    input  logic [31:0] inst_data,
    output logic [31:0] data_addr,
    input  logic [31:0] data_rd,
    output logic [31:0] data_wr,
    output logic [3:0]  data_wr_en
);

    state_t      state, next_state;
    logic [31:0] pc, next_pc;
    logic [31:0] xreg [0:31];

    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic        alt;
    logic [31:0] rs1_val, rs2_val, ea, alu_b, alu_result;
    logic        alu_eq, alu_lt, alu_ltu, taken;
    alu_op_t     alu_op;

    logic [4:0]  ld_rd;
    logic [2:0]  ld_funct3;
    logic [1:0]  ld_off;
    logic [29:0] ld_word;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_val;

    logic        wb_en, load_start;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    assign opcode    = inst_data[6:0];
    assign rd        = inst_data[11:7];
    assign funct3    = inst_data[14:12];
    assign rs1       = inst_data[19:15];
    assign rs2       = inst_data[24:20];
    assign alt       = inst_data[30];
    assign inst_addr = pc;

    assign rs1_val = (rs1 == 5'd0) ? 32'd0 : xreg[rs1];
    assign rs2_val = (rs2 == 5'd0) ? 32'd0 : xreg[rs2];
    // One address adder serves loads, stores and the JALR target.
    assign ea      = rs1_val + ((opcode == OPC_STORE) ? imm_s(inst_data[31:25], inst_data[11:7])
                                                      : imm_i(inst_data[31:20]));
    assign alu_b   = (opcode == OPC_OP || opcode == OPC_BRANCH) ? rs2_val : imm_i(inst_data[31:20]);

    always_comb begin
        alu_op = ALU_ADD;
        case (funct3)
            F3_ADD:  alu_op = (opcode == OPC_OP && alt) ? ALU_SUB : ALU_ADD;
            F3_SLL:  alu_op = ALU_SLL;
            F3_SLT:  alu_op = ALU_SLT;
            F3_SLTU: alu_op = ALU_SLTU;
            F3_XOR:  alu_op = ALU_XOR;
            F3_SR:   alu_op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:   alu_op = ALU_OR;
            F3_AND:  alu_op = ALU_AND;
            default: alu_op = ALU_ADD;
        endcase
    end

    riscv_alu u_alu (
        .op     (alu_op),
        .a      (rs1_val),
        .b      (alu_b),
        .result (alu_result),
        .eq     (alu_eq),
        .lt     (alu_lt),
        .ltu    (alu_ltu)
    );

    always_comb begin
        taken = 1'b0;
        case (funct3)
            F3_BEQ:  taken = alu_eq;
            F3_BNE:  taken = !alu_eq;
            F3_BLT:  taken = alu_lt;
            F3_BGE:  taken = !alu_lt;
            F3_BLTU: taken = alu_ltu;
            F3_BGEU: taken = !alu_ltu;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        ld_byte = data_rd[{ld_off, 3'b000} +: 8];
        ld_half = ld_off[1] ? data_rd[31:16] : data_rd[15:0];
        case (ld_funct3)
            F3_B:    ld_val = {{24{ld_byte[7]}}, ld_byte};
            F3_BU:   ld_val = {24'b0, ld_byte};
            F3_H:    ld_val = {{16{ld_half[15]}}, ld_half};
            F3_HU:   ld_val = {16'b0, ld_half};
            default: ld_val = data_rd;
        endcase
    end

    always_comb begin
        next_state = ST_EXEC;
        next_pc    = pc + 32'd4;
        wb_en      = 1'b0;
        wb_rd      = rd;
        wb_data    = '0;
        load_start = 1'b0;
        data_addr  = {2'b00, ea[31:2]};
        data_wr    = '0;
        data_wr_en = '0;
        if (state == ST_LOAD_WB) begin
            data_addr = {2'b00, ld_word};
            wb_en     = 1'b1;
            wb_rd     = ld_rd;
            wb_data   = ld_val;
        end else begin
            case (opcode)
                OPC_LUI: begin
                    wb_en   = 1'b1;
                    wb_data = imm_u(inst_data[31:12]);
                end
                OPC_AUIPC: begin
                    wb_en   = 1'b1;
                    wb_data = pc + imm_u(inst_data[31:12]);
                end
                OPC_JAL: begin
                    wb_en   = 1'b1;
                    wb_data = pc + 32'd4;
                    next_pc = pc + imm_j(inst_data[31:12]);
                end
                OPC_JALR: begin
                    wb_en   = 1'b1;
                    wb_data = pc + 32'd4;
                    next_pc = {ea[31:1], 1'b0};
                end
                OPC_BRANCH: begin
                    if (taken) next_pc = pc + imm_b(inst_data[31:25], inst_data[11:7]);
                end
                OPC_LOAD: begin
                    next_pc    = pc;
                    next_state = ST_LOAD_WB;
                    load_start = 1'b1;
                end
                OPC_STORE: begin
                    case (funct3)
                        F3_B: begin
                            data_wr    = {4{rs2_val[7:0]}};
                            data_wr_en = 4'b0001 << ea[1:0];
                        end
                        F3_H: begin
                            data_wr    = {2{rs2_val[15:0]}};
                            data_wr_en = ea[1] ? 4'b1100 : 4'b0011;
                        end
                        F3_W: begin
                            data_wr    = rs2_val;
                            data_wr_en = 4'b1111;
                        end
                        default: data_wr_en = 4'b0000;
                    endcase
                end
                OPC_OPIMM, OPC_OP: begin
                    wb_en   = 1'b1;
                    wb_data = alu_result;
                end
                default: wb_en = 1'b0;
            endcase
        end
        if (!resetn) data_wr_en = 4'b0000;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= ST_EXEC;
            pc        <= RESET_PC;
            ld_rd     <= '0;
            ld_funct3 <= '0;
            ld_off    <= '0;
            ld_word   <= '0;
            for (int i = 0; i < 32; i++) xreg[i] <= '0;
        end else begin
            state <= next_state;
            pc    <= next_pc;
            if (wb_en && wb_rd != 5'd0) xreg[wb_rd] <= wb_data;
            if (load_start) begin
                ld_rd     <= rd;
                ld_funct3 <= funct3;
                ld_off    <= ea[1:0];
                ld_word   <= ea[31:2];
            end
        end
    end

endmodule

// File: tb/tb_riscv_cpu.sv
// tb/tb_riscv_cpu.sv - scoreboard bench for riscv_cpu with a 1-cycle-read data RAM model
module tb_riscv_cpu;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] inst_addr, inst_data, data_addr, data_rd, data_wr;
    logic [3:0]  data_wr_en;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  vectors     = 0;
    int  miscompares = 0;

    logic [31:0] mem [0:15];
    logic [31:0] rd_q;

    always #5 clk = ~clk;

    riscv_cpu #(.RESET_PC(32'h0)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .inst_addr  (inst_addr),
        .inst_data  (inst_data),
        .data_addr  (data_addr),
        .data_rd    (data_rd),
        .data_wr    (data_wr),
        .data_wr_en (data_wr_en)
    );

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (data_wr_en[i]) mem[data_addr[3:0]][8*i +: 8] <= data_wr[8*i +: 8];
        rd_q <= mem[data_addr[3:0]];
    end
    assign data_rd = rd_q;

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction

    task automatic drive(input logic [31:0] inst);
        inst_data = inst;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic [31:0] inst);
        drive(inst);
        tick();
    endtask

    task automatic li(input logic [4:0] rd, input logic [31:0] v);
        logic [31:0] up;
        up = v + 32'h800;
        step({up[31:12], rd, 7'h37});
        step(enc_i(v[11:0], rd, 3'd0, rd, 7'h13));
    endtask

    task automatic test_reset();
        sb_t e;
        resetn = 1'b0;
        sb_q.push_back('{name: "reset_wr_en", exp: 32'h0});
        drive(32'h00302023);
        e = sb_q.pop_front(); vectors++;
        if ({28'b0, data_wr_en} !== e.exp) begin
            miscompares++; $display("FAIL %s: got %h expected %h", e.name, data_wr_en, e.exp);
        end
        sb_q.push_back('{name: "reset_pc", exp: 32'h0});
        sb_q.push_back('{name: "reset_x3", exp: 32'h0});
        tick(); tick();
        e = sb_q.pop_front(); vectors++;
        if (dut.pc !== e.exp) begin
            miscompares++; $display("FAIL %s: got %h expected %h", e.name, dut.pc, e.exp);
        end
        e = sb_q.pop_front(); vectors++;
        if (dut.xreg[3] !== e.exp) begin
            miscompares++; $display("FAIL %s: got %h expected %h", e.name, dut.xreg[3], e.exp);
        end
        drive(32'h00000013);
        resetn = 1'b1;
    endtask

    task automatic test_nop();
        sb_t e;
        sb_q.push_back('{name: "nop_wr_en", exp: 32'h0});
        sb_q.push_back('{name: "nop_pc", exp: 32'h4});
        sb_q.push_back('{name: "nop_inst_addr", exp: 32'h4});
        sb_q.push_back('{name: "nop_x1", exp: 32'h0});
        drive(32'h00000013);
        e = sb_q.pop_front(); vectors++;
        if ({28'b0, data_wr_en} !== e.exp) begin
            miscompares++; $display("FAIL %s: got %h expected %h", e.name, data_wr_en, e.exp);
        end
        tick();
        e = sb_q.pop_front(); vectors++;
        if (dut.pc !== e.exp) begin
            miscompares++; $display("FAIL %s: got %h expected %h", e.name, dut.pc, e.exp);
        end
        e = sb_q.pop_front(); vectors++;
        if (inst_addr !== e.exp) begin
            miscompares++; $display("FAIL %s: got %h expected %h", e.name, inst_addr, e.exp);
        end
        e = sb_q.pop_front(); vectors++;
        if (dut.xreg[1] !== e.exp) begin
            miscompares++; $display("FAIL %s: got %h expected %h", e.name, dut.xreg[1], e.exp);
        end
    endtask

    task automatic test_addi();
        sb_t e;
        sb_q.push_back('{name: "addi_x1", exp: 32'h34});
        step(32'h03400093);
        e = sb_q.pop_front(); vectors++;
        if (dut.xreg[1] !== e.exp) begin
            miscompares++; $display("FAIL %s: got %h expected %h", e.name, dut.xreg[1], e.exp);
        end
        step(32'h00000013);
        sb_q.push_back('{name: "x0_discard", exp: 32'h0});
        step(32'h00500013);
        e = sb_q.pop_front(); vectors++;
        if (dut.xreg[0] !== e.exp) begin
            miscompares++; $display("FAIL %s: got %h expected %h", e.name, dut.xreg[0], e.exp);
        end
    endtask

    task automatic test_store();
        sb_t e;
        logic [31:0] exp_b [4];
        logic [31:0] exp_h [2];
        logic [3:0]  en_h  [2];
        exp_b = '{32'hffffff01, 32'hffff01ff, 32'hff01ffff, 32'h01ffffff};
        exp_h = '{32'hffff0001, 32'h0001ffff};
        en_h  = '{4'b0011, 4'b1100};
        step(32'h00100113);
        step(32'hfff00193);
        for (int k = 0; k < 4; k++) begin
            step(32'h00302023);
            step(enc_i(12'(k), 5'd0, 3'd0, 5'd1, 7'h13));
            sb_q.push_back('{name: "sb_wr_en", exp: {28'b0, 4'b0001 << k}});
            sb_q.push_back('{name: "sb_mem", exp: exp_b[k]});
            drive(32'h00208023);
            e = sb_q.pop_front(); vectors++;
            if ({28'b0, data_wr_en} !== e.exp) begin
                miscompares++; $display("FAIL %s[%0d]: got %h expected %h", e.name, k, data_wr_en, e.exp);
            end
            tick();
            e = sb_q.pop_front(); vectors++;
            if (mem[0] !== e.exp) begin
                miscompares++; $display("FAIL %s[%0d]: got %h expected %h", e.name, k, mem[0], e.exp);
            end
        end
        for (int k = 0; k < 2; k++) begin
            step(32'h00302023);
            step(enc_i(12'(2 * k), 5'd0, 3'd0, 5'd1, 7'h13));
            sb_q.push_back('{name: "sh_wr_en", exp: {28'b0, en_h[k]}});
            sb_q.push_back('{name: "sh_mem", exp: exp_h[k]});
            drive(32'h00209023);
            e = sb_q.pop_front(); vectors++;
            if ({28'b0, data_wr_en} !== e.exp) begin
                miscompares++; $display("FAIL %s[%0d]: got %h expected %h", e.name, k, data_wr_en, e.exp);
            end
            tick();
            e = sb_q.pop_front(); vectors++;
            if (mem[0] !== e.exp) begin
                miscompares++; $display("FAIL %s[%0d]: got %h expected %h", e.name, k, mem[0], e.exp);
            end
        end
        step(32'h00302023);
        sb_q.push_back('{name: "sw_mem", exp: 32'h00000001});
        step(32'h0020a023);
        e = sb_q.pop_front(); vectors++;
        if (mem[0] !== e.exp) begin
            miscompares++; $display("FAIL %s: got %h expected %h", e.name, mem[0], e.exp);
        end
    endtask

    task automatic test_load();
        sb_t e;
        logic [31:0] pc0;
        logic [31:0] vals [9];
        logic [31:0] insts [9];
        logic [31:0] exps [9];
        vals  = '{32'h90A0B0C0, 32'h90A0B0C0, 32'h90A0B0C0, 32'h90A0B0C0, 32'h90A0B0C0,
                  32'h91A1B1C1, 32'h91A1B1C1, 32'h91A1B1C1, 32'h92A2B2C2};
        insts = '{32'h00000103, 32'h00100103, 32'h00200103, 32'h00300103, 32'h00304103,
                  32'h00001103, 32'h00201103, 32'h00205103, 32'h00002103};
        exps  = '{32'hffffffc0, 32'hffffffb0, 32'hffffffa0, 32'hffffff90, 32'h00000090,
                  32'hffffb1c1, 32'hffff91a1, 32'h000091a1, 32'h92a2b2c2};
        for (int k = 0; k < 9; k++) begin
            li(5'd3, vals[k]);
            step(32'h00302023);
            pc0 = dut.pc;
            sb_q.push_back('{name: "load_pc_hold", exp: pc0});
            sb_q.push_back('{name: "load_pc_next", exp: pc0 + 32'd4});
            sb_q.push_back('{name: "load_x2", exp: exps[k]});
            step(insts[k]);
            e = sb_q.pop_front(); vectors++;
            if (dut.pc !== e.exp) begin
                miscompares++; $display("FAIL %s[%0d]: got %h expected %h", e.name, k, dut.pc, e.exp);
            end
            tick();
            e = sb_q.pop_front(); vectors++;
            if (dut.pc !== e.exp) begin
                miscompares++; $display("FAIL %s[%0d]: got %h expected %h", e.name, k, dut.pc, e.exp);
            end
            e = sb_q.pop_front(); vectors++;
            if (dut.xreg[2] !== e.exp) begin
                miscompares++; $display("FAIL %s[%0d]: got %h expected %h", e.name, k, dut.xreg[2], e.exp);
            end
        end
    endtask

    task automatic test_jal();
        sb_t e;
        logic [31:0] pc0;
        repeat (5) step(32'h00000013);
        pc0 = dut.pc;
        sb_q.push_back('{name: "jal_x0_pc", exp: pc0 - 32'd20});
        step(32'hfedff06f);
        e = sb_q.pop_front(); vectors++;
        if (dut.pc !== e.exp) begin
            miscompares++; $display("FAIL %s: got %h expected %h", e.name, dut.pc, e.exp);
        end
        pc0 = dut.pc;
        sb_q.push_back('{name: "jal_x1_pc", exp: pc0 - 32'd20});
        sb_q.push_back('{name: "jal_x1_link", exp: pc0 + 32'd4});
        step(32'hfedff0ef);
        e = sb_q.pop_front(); vectors++;
        if (dut.pc !== e.exp) begin
            miscompares++; $display("FAIL %s: got %h expected %h", e.name, dut.pc, e.exp);
        end
        e = sb_q.pop_front(); vectors++;
        if (dut.xreg[1] !== e.exp) begin
            miscompares++; $display("FAIL %s: got %h expected %h", e.name, dut.xreg[1], e.exp);
        end
    endtask

    task automatic test_branch_op();
        sb_t e;
        logic [31:0] pc0;
        logic [31:0] br_inst [4];
        logic [31:0] br_off  [4];
        string       br_name [4];
        step(enc_i(12'd5, 5'd0, 3'd0, 5'd4, 7'h13));
        step(enc_i(12'hfff, 5'd0, 3'd0, 5'd13, 7'h13));
        br_inst = '{enc_b(13'd8, 5'd4, 5'd4, 3'd0), enc_b(13'd8, 5'd0, 5'd4, 3'd0),
                    enc_b(13'h1ff8, 5'd0, 5'd13, 3'd4), enc_b(13'd12, 5'd0, 5'd13, 3'd6)};
        br_off  = '{32'd8, 32'd4, 32'hfffffff8, 32'd4};
        br_name = '{"beq_taken", "beq_not_taken", "blt_neg_taken", "bltu_not_taken"};
        for (int k = 0; k < 4; k++) begin
            pc0 = dut.pc;
            sb_q.push_back('{name: br_name[k], exp: pc0 + br_off[k]});
            step(br_inst[k]);
            e = sb_q.pop_front(); vectors++;
            if (dut.pc !== e.exp) begin
                miscompares++; $display("FAIL %s: got %h expected %h", e.name, dut.pc, e.exp);
            end
        end
        step(enc_i(12'd5, 5'd0, 3'd0, 5'd5, 7'h13));
        step(enc_i(12'd7, 5'd0, 3'd0, 5'd6, 7'h13));
        sb_q.push_back('{name: "sub", exp: 32'hfffffffe});
        step(enc_r(7'h20, 5'd6, 5'd5, 3'd0, 5'd7));
        e = sb_q.pop_front(); vectors++;
        if (dut.xreg[7] !== e.exp) begin
            miscompares++; $display("FAIL %s: got %h expected %h", e.name, dut.xreg[7], e.exp);
        end
        step({20'h80000, 5'd8, 7'h37});
        sb_q.push_back('{name: "srai", exp: 32'hf8000000});
        step(enc_i(12'h404, 5'd8, 3'd5, 5'd9, 7'h13));
        e = sb_q.pop_front(); vectors++;
        if (dut.xreg[9] !== e.exp) begin
            miscompares++; $display("FAIL %s: got %h expected %h", e.name, dut.xreg[9], e.exp);
        end
        step(enc_i(12'd1, 5'd0, 3'd0, 5'd10, 7'h13));
        step(enc_i(12'hfff, 5'd0, 3'd0, 5'd11, 7'h13));
        sb_q.push_back('{name: "sltu", exp: 32'h1});
        step(enc_r(7'h00, 5'd11, 5'd10, 3'd3, 5'd12));
        e = sb_q.pop_front(); vectors++;
        if (dut.xreg[12] !== e.exp) begin
            miscompares++; $display("FAIL %s: got %h expected %h", e.name, dut.xreg[12], e.exp);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        inst_data = 32'h00000013;
        resetn    = 1'b0;
        test_reset();
        test_nop();
        test_addi();
        test_store();
        test_load();
        test_jal();
        test_branch_op();
        vectors++;
        if (sb_q.size() != 0) begin
            miscompares++; $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
